integrator_seq_ctrl: RTL and testbench

INTEGRATOR_SEQ_CTRL -- requirements
Module: integrator_seq_ctrl

---
 rtl/integrator_seq_ctrl.sv | 136 +++++++++++++
 tb/tb_integrator_seq_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/integrator_seq_ctrl.sv
// ============================================================================
// integrator_seq_ctrl -- frame sequencer for an integrate-and-dump datapath.
// Optional feature macro: INTEG_CTRL_AUTO_RESTART_EN (DONE re-enters RUN).
// Revision: 1.0
// ============================================================================
`default_nettype none

module integrator_seq_ctrl #(
   parameter int word_length = 8,
   parameter int latency     = 4
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   start,
   input  logic                   abort,
   input  logic [word_length-1:0] frame_len,
   output logic                   hold,
   output logic                   LSB_flag,
   output logic                   dump,
   output logic                   done,
   output logic                   busy,
   output logic [word_length-1:0] sample_count
);

   localparam logic [1:0] c_IDLE  = 2'd0;
   localparam logic [1:0] c_RUN   = 2'd1;
   localparam logic [1:0] c_FLUSH = 2'd2;
   localparam logic [1:0] c_DONE  = 2'd3;

   localparam logic [3:0]             c_LAT_M1 = 4'(latency - 1);
   localparam logic [word_length-1:0] c_ONE    = {{(word_length-1){1'b0}}, 1'b1};
   localparam logic [word_length-1:0] c_ZERO   = '0;

   logic [1:0]             r_state;
   logic [word_length-1:0] r_len;
   logic [word_length-1:0] r_cnt;
   logic [3:0]             r_flush;
   logic                   r_hold;
   logic                   r_lsb;
   logic                   r_dump;
   logic                   r_done;
   logic                   r_busy;

   logic [1:0]             w_next_state;
   logic [word_length-1:0] w_next_len;
   logic [word_length-1:0] w_next_cnt;
   logic [word_length-1:0] w_cnt_inc;
   logic [3:0]             w_next_flush;
   logic                   w_first;

   assign w_cnt_inc = r_cnt + c_ONE;

   always_comb begin
      w_next_state = r_state;
      w_next_len   = r_len;
      w_next_cnt   = r_cnt;
      w_next_flush = r_flush;
      w_first      = 1'b0;
      case (r_state)
         c_IDLE: begin
            if (start && !abort && (frame_len != c_ZERO)) begin
               w_next_state = c_RUN;
               w_next_len   = frame_len;
               w_next_cnt   = c_ZERO;
               w_first      = 1'b1;
            end
         end
         c_RUN: begin
            // The sample presented in this cycle is accepted even when aborting.
            w_next_cnt = w_cnt_inc;
            if (abort) begin
               w_next_state = c_IDLE;
            end else if (w_cnt_inc == r_len) begin
               w_next_state = c_FLUSH;
               w_next_flush = c_LAT_M1;
            end
         end
         c_FLUSH: begin
            if (abort) begin
               w_next_state = c_IDLE;
            end else if (r_flush == 4'd0) begin
               w_next_state = c_DONE;
            end else begin
               w_next_flush = r_flush - 4'd1;
            end
         end
         c_DONE: begin
`ifdef INTEG_CTRL_AUTO_RESTART_EN
            w_next_state = c_RUN;
            w_next_cnt   = c_ZERO;
            w_first      = 1'b1;
`else
            w_next_state = c_IDLE;
`endif
         end
         default: begin
            w_next_state = c_IDLE;
         end
      endcase
   end

   // Outputs are derived from the next state so they align with the state register.
   always_ff @(posedge clock) begin
      if (!reset) begin
         r_state <= c_IDLE;
         r_len   <= c_ZERO;
         r_cnt   <= c_ZERO;
         r_flush <= 4'd0;
         r_hold  <= 1'b1;
         r_lsb   <= 1'b0;
         r_dump  <= 1'b0;
         r_done  <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_next_state;
         r_len   <= w_next_len;
         r_cnt   <= w_next_cnt;
         r_flush <= w_next_flush;
         r_hold  <= (w_next_state != c_RUN);
         r_lsb   <= w_first;
         r_dump  <= (w_next_state == c_DONE);
         r_done  <= (w_next_state == c_DONE);
         r_busy  <= (w_next_state != c_IDLE);
      end
   end

   assign hold         = r_hold;
   assign LSB_flag     = r_lsb;
   assign dump         = r_dump;
   assign done         = r_done;
   assign busy         = r_busy;
   assign sample_count = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_integrator_seq_ctrl.sv
// ============================================================================
// tb_integrator_seq_ctrl -- vector table, corner sequences and random traffic
// checked against a frame-timeline model. Honors INTEG_CTRL_AUTO_RESTART_EN.
// ============================================================================
`default_nettype none

module tb_integrator_seq_ctrl;

   localparam int LAT = 4;

   logic       clock = 1'b0;
   logic       reset_n;
   logic       start;
   logic       abort;
   logic [7:0] frame_len;
   logic       hold, LSB_flag, dump, done, busy;
   logic [7:0] sample_count;

   integrator_seq_ctrl #(.word_length(8), .latency(LAT)) dut (
      .clock        (clock),
      .reset        (reset_n),
      .start        (start),
      .abort        (abort),
      .frame_len    (frame_len),
      .hold         (hold),
      .LSB_flag     (LSB_flag),
      .dump         (dump),
      .done         (done),
      .busy         (busy),
      .sample_count (sample_count)
   );

   always #5 clock = ~clock;

   wire logic [12:0] w_act = {hold, LSB_flag, dump, done, busy, sample_count};

   typedef struct {
      bit         rst_n;
      bit         st;
      bit         ab;
      logic [7:0] len;
      logic [12:0] exp;
   } vec_t;

   vec_t tbl[$];
   int   checks = 0;
   int   errors = 0;

   // Model: a frame is a timeline indexed by cycle number k since the accepting edge.
   bit m_active = 0;
   int m_k      = 0;
   int m_L      = 0;
   int m_cnt    = 0;

   function automatic logic [12:0] pk(bit h, bit l, bit dm, bit dn, bit b, int c);
      return {h, l, dm, dn, b, 8'(c)};
   endfunction

   function automatic vec_t mk(bit r, bit s, bit a, int len, logic [12:0] e);
      vec_t v;
      v.rst_n = r; v.st = s; v.ab = a; v.len = 8'(len); v.exp = e;
      return v;
   endfunction

   function automatic logic [12:0] model_exp();
      if (!m_active)            return pk(1, 0, 0, 0, 0, m_cnt);
      else if (m_k <= m_L)      return pk(0, m_k == 1, 0, 0, 1, m_k - 1);
      else if (m_k <= m_L + LAT) return pk(1, 0, 0, 0, 1, m_L);
      else                      return pk(1, 0, 1, 1, 1, m_L);
   endfunction

   task automatic model_step(bit r, bit s, bit a, int len);
      if (!r) begin
         m_active = 0;
         m_cnt    = 0;
      end else if (m_active) begin
         if (m_k <= m_L + LAT) begin
            if (a) begin
               m_cnt    = (m_k <= m_L) ? m_k : m_L;
               m_active = 0;
            end else begin
               m_k++;
            end
         end else begin
`ifdef INTEG_CTRL_AUTO_RESTART_EN
            m_k = 1;
`else
            m_active = 0;
            m_cnt    = m_L;
`endif
         end
      end else if (s && !a && len != 0) begin
         m_active = 1;
         m_k      = 1;
         m_L      = len;
      end
   endtask

   task automatic step(bit r, bit s, bit a, int len);
      reset_n   = r;
      start     = s;
      abort     = a;
      frame_len = 8'(len);
      @(posedge clock);
      model_step(r, s, a, len);
      #1;
   endtask

   task automatic chk(string name, logic [12:0] act, logic [12:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got {hold,lsb,dump,done,busy,cnt}=%h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_bit(string name, bit act, bit exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   initial begin
      bit seen_done;
      bit d7, d14, l8, b0;

      reset_n = 1'b0; start = 1'b0; abort = 1'b0; frame_len = 8'd0;

      // Nominal frame, zero-length start, abort-over-start, ignored mid-frame inputs.
      tbl.push_back(mk(0, 0, 0, 0, pk(1, 0, 0, 0, 0, 0)));
      tbl.push_back(mk(1, 1, 0, 0, pk(1, 0, 0, 0, 0, 0)));
      tbl.push_back(mk(1, 1, 1, 3, pk(1, 0, 0, 0, 0, 0)));
      tbl.push_back(mk(1, 1, 0, 5, pk(0, 1, 0, 0, 1, 0)));
      tbl.push_back(mk(1, 1, 0, 9, pk(0, 0, 0, 0, 1, 1)));
      tbl.push_back(mk(1, 0, 0, 9, pk(0, 0, 0, 0, 1, 2)));
      tbl.push_back(mk(1, 0, 0, 9, pk(0, 0, 0, 0, 1, 3)));
      tbl.push_back(mk(1, 0, 0, 9, pk(0, 0, 0, 0, 1, 4)));
      tbl.push_back(mk(1, 0, 0, 9, pk(1, 0, 0, 0, 1, 5)));
      tbl.push_back(mk(1, 1, 0, 9, pk(1, 0, 0, 0, 1, 5)));
      tbl.push_back(mk(1, 0, 0, 0, pk(1, 0, 0, 0, 1, 5)));
      tbl.push_back(mk(1, 0, 0, 0, pk(1, 0, 0, 0, 1, 5)));
      tbl.push_back(mk(1, 0, 0, 0, pk(1, 0, 1, 1, 1, 5)));
`ifdef INTEG_CTRL_AUTO_RESTART_EN
      tbl.push_back(mk(1, 0, 0, 0, pk(0, 1, 0, 0, 1, 0)));
      tbl.push_back(mk(1, 0, 1, 0, pk(1, 0, 0, 0, 0, 1)));
`else
      tbl.push_back(mk(1, 0, 0, 0, pk(1, 0, 0, 0, 0, 5)));
      tbl.push_back(mk(1, 0, 1, 0, pk(1, 0, 0, 0, 0, 5)));
`endif

      for (int i = 0; i < tbl.size(); i++) begin
         step(tbl[i].rst_n, tbl[i].st, tbl[i].ab, int'(tbl[i].len));
         chk($sformatf("vec%0d", i), w_act, tbl[i].exp);
      end

      // Abort in RUN cycle 3 of an 8-sample frame.
      step(0, 0, 0, 0);
      step(1, 1, 0, 8);
      step(1, 0, 0, 0);
      step(1, 0, 0, 0);
      step(1, 0, 1, 0);
      chk("abort_run", w_act, pk(1, 0, 0, 0, 0, 3));
      seen_done = 0;
      for (int i = 0; i < 12; i++) begin
         step(1, 0, 0, 0);
         if (done || dump) seen_done = 1;
      end
      chk_bit("abort_no_done", seen_done, 0);
      chk("abort_hold_cnt", w_act, pk(1, 0, 0, 0, 0, 3));

      // Abort during FLUSH keeps the full count.
      step(1, 1, 0, 2);
      step(1, 0, 0, 0);
      step(1, 0, 0, 0);
      chk("flush_entry", w_act, pk(1, 0, 0, 0, 1, 2));
      step(1, 0, 1, 0);
      chk("abort_flush", w_act, pk(1, 0, 0, 0, 0, 2));

      // Reset held for two edges mid-RUN, with start and abort also asserted.
      step(1, 1, 0, 6);
      step(1, 0, 0, 0);
      step(0, 1, 1, 6);
      step(0, 1, 0, 6);
      chk("reset_mid_run", w_act, pk(1, 0, 0, 0, 0, 0));
      step(1, 0, 0, 0);
      chk("reset_release", w_act, pk(1, 0, 0, 0, 0, 0));

`ifdef INTEG_CTRL_AUTO_RESTART_EN
      d7 = 0; d14 = 0; l8 = 0; b0 = 0;
      step(1, 1, 0, 2);
      for (int c = 1; c <= 14; c++) begin
         if (c == 7)  d7  = done;
         if (c == 8)  l8  = LSB_flag;
         if (c == 14) d14 = done;
         if (!busy) b0 = 1;
         if (c < 14) step(1, 0, 0, 0);
      end
      chk_bit("auto_done7", d7, 1);
      chk_bit("auto_lsb8", l8, 1);
      chk_bit("auto_done14", d14, 1);
      chk_bit("auto_busy", b0, 0);
      step(1, 0, 1, 0);
      step(1, 0, 1, 0);
      chk("auto_abort", w_act, pk(1, 0, 0, 0, 0, 0));
`else
      d7 = 0; d14 = 0; l8 = 0; b0 = 0;
      step(1, 1, 0, 2);
      for (int c = 1; c <= 9; c++) begin
         if (c == 7) d7 = done;
         if (c == 8) b0 = busy;
         if (c < 9) step(1, 0, 0, 0);
      end
      chk_bit("len2_done7", d7, 1);
      chk_bit("len2_idle8", b0, 0);
`endif

      // Random traffic against the timeline model.
      step(0, 0, 0, 0);
      chk("rand_reset", w_act, model_exp());
      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, 39) != 0,
              $urandom_range(0, 3) == 0,
              $urandom_range(0, 24) == 0,
              int'($urandom_range(0, 9)));
         chk($sformatf("rand%0d", i), w_act, model_exp());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
